// File: rtl/conv_window3_pkg.sv
// Shared constants, element type and window index helper for the 3x3 window generator.
package conv_pkg;

  localparam int K          = 3;
  localparam int ELEM_WIDTH = 8;

  typedef logic signed [ELEM_WIDTH-1:0] elem_t;

  // Flat window index: r/c = 0 is the oldest row/column.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned ch, input int unsigned n_ch);
    return (r * K + c) * n_ch + ch;
  endfunction

endpackage

// File: rtl/conv_window3_line_buffer.sv
// Single-port line buffer: combinational read at addr, write on the same address when en.
module line_buffer #(
  parameter  int DEPTH = 28,
  parameter  int DW    = 24,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window3.sv
// Streaming 3x3 valid-convolution window generator over a raster pixel stream.
// Optional win_last output enabled by defining CONV_WINDOW3_LAST_EN.
module conv_window3
  import conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 3,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic signed [WIDTH-1:0] pix_data [CH],
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic signed [WIDTH-1:0] window [K*K*CH]
`ifdef CONV_WINDOW3_LAST_EN
  ,
  output logic                    win_last
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = WIDTH * CH;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          load;
  logic [DW-1:0] pix_flat;
  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1;

  // Only the two older columns are registered; the third comes straight from the
  // line buffers and the input, so the window loads in the same edge as the accept.
  logic signed [WIDTH-1:0] sr     [K-1][K][CH];
  logic signed [WIDTH-1:0] newcol [K][CH];

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign load      = accept && (row >= ROW_FIRST) && (col >= COL_FIRST);

  always_comb begin
    pix_flat = '0;
    newcol   = '{default: '0};
    for (int unsigned ch = 0; ch < CH; ch++) begin
      pix_flat[ch*WIDTH +: WIDTH] = pix_data[ch];
      newcol[0][ch]               = rd1[ch*WIDTH +: WIDTH];
      newcol[1][ch]               = rd0[ch*WIDTH +: WIDTH];
      newcol[2][ch]               = pix_data[ch];
    end
  end

  line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb_row1 (
    .clk   (clk),
    .en    (accept),
    .addr  (col),
    .wdata (pix_flat),
    .rdata (rd0)
  );

  line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb_row2 (
    .clk   (clk),
    .en    (accept),
    .addr  (col),
    .wdata (rd0),
    .rdata (rd1)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      sr[0] <= sr[1];
      sr[1] <= newcol;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
`ifdef CONV_WINDOW3_LAST_EN
      win_last  <= 1'b0;
`endif
      for (int unsigned i = 0; i < K*K*CH; i++) window[i] <= '0;
    end else begin
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (load) begin
        win_valid <= 1'b1;
`ifdef CONV_WINDOW3_LAST_EN
        win_last  <= (row == ROW_LAST) && (col == COL_LAST);
`endif
        for (int unsigned r = 0; r < K; r++) begin
          for (int unsigned c = 0; c < K; c++) begin
            for (int unsigned ch = 0; ch < CH; ch++) begin
              if (c == 0)      window[win_idx(r, c, ch, CH)] <= sr[0][r][ch];
              else if (c == 1) window[win_idx(r, c, ch, CH)] <= sr[1][r][ch];
              else             window[win_idx(r, c, ch, CH)] <= newcol[r][ch];
            end
          end
        end
      end else if (win_ready) begin
        win_valid <= 1'b0;
`ifdef CONV_WINDOW3_LAST_EN
        win_last  <= 1'b0;
`endif
      end
    end
  end

endmodule
